// File: rtl/wb_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : wb_unit_if
//  Description : Bundles the writeback unit's handshake, register-bank write
//                port and bypass-lookup signals.
//                slave  modport : the writeback unit itself
//                master modport : the producer/consumer side around it
//                Ports: flush/drain controls, LSU and ALU valid/ready result
//                channels, bank write strobe/data/address, two bypass queries.
//  Revision    : 1.0 - initial release
// ============================================================================
interface wb_unit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              flush_i;
    logic              wb_en_i;

    logic              lsu_valid_i;
    logic              lsu_ready_o;
    logic [DATA_W-1:0] lsu_data_i;
    logic [ADDR_W-1:0] lsu_addr_i;

    logic              alu_valid_i;
    logic              alu_ready_o;
    logic [DATA_W-1:0] alu_data_i;
    logic [ADDR_W-1:0] alu_addr_i;

    logic              valid_out_o;
    logic [DATA_W-1:0] data_out_o;
    logic [ADDR_W-1:0] addr_out_o;

    logic [ADDR_W-1:0] q1_addr_i;
    logic [ADDR_W-1:0] q2_addr_i;
    logic              q1_hit_o;
    logic              q2_hit_o;
    logic [DATA_W-1:0] q1_data_o;
    logic [DATA_W-1:0] q2_data_o;

    modport slave (
        input  flush_i, wb_en_i,
        input  lsu_valid_i, lsu_data_i, lsu_addr_i,
        output lsu_ready_o,
        input  alu_valid_i, alu_data_i, alu_addr_i,
        output alu_ready_o,
        output valid_out_o, data_out_o, addr_out_o,
        input  q1_addr_i, q2_addr_i,
        output q1_hit_o, q2_hit_o, q1_data_o, q2_data_o
    );

    modport master (
        output flush_i, wb_en_i,
        output lsu_valid_i, lsu_data_i, lsu_addr_i,
        input  lsu_ready_o,
        output alu_valid_i, alu_data_i, alu_addr_i,
        input  alu_ready_o,
        input  valid_out_o, data_out_o, addr_out_o,
        output q1_addr_i, q2_addr_i,
        input  q1_hit_o, q2_hit_o, q1_data_o, q2_data_o
    );
endinterface
`default_nettype wire

// File: rtl/wb_unit.sv
`default_nettype none
// ============================================================================
//  Module      : wb_unit
//  Description : Writeback unit in front of the register bank write port.
//                Accepts LSU (priority) and ALU results, queues them in an
//                in-order FIFO, drains at most one per cycle to the bank and
//                offers a youngest-wins bypass view of in-flight writes.
//                Ports: clk, rst (sync, active-high), bus (wb_unit_if.slave).
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
) (
    input  wire logic   clk,
    input  wire logic   rst,
    wb_unit_if.slave    bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    // FIFO storage (no reset needed: only entries below count are ever read)
    logic [DATA_W-1:0] r_mem_data [DEPTH];
    logic [ADDR_W-1:0] r_mem_addr [DEPTH];

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_valid_out;
    logic [DATA_W-1:0] r_data_out;
    logic [ADDR_W-1:0] r_addr_out;

    logic              w_ready;
    logic              w_alu_ready;
    logic              w_lsu_fire;
    logic              w_alu_fire;
    logic              w_push;
    logic              w_pop;
    logic [DATA_W-1:0] w_enq_data;
    logic [ADDR_W-1:0] w_enq_addr;

    logic              w_q1_hit;
    logic              w_q2_hit;
    logic [DATA_W-1:0] w_q1_data;
    logic [DATA_W-1:0] w_q2_data;

    // Ready depends on registered count only, so a dequeue from a full FIFO
    // reopens ready one cycle later.
    assign w_ready     = !rst && !bus.flush_i && (r_count < C_DEPTH);
    assign w_alu_ready = w_ready && !bus.lsu_valid_i;

    assign w_lsu_fire  = bus.lsu_valid_i && w_ready;
    assign w_alu_fire  = bus.alu_valid_i && w_alu_ready;
    assign w_enq_data  = w_lsu_fire ? bus.lsu_data_i : bus.alu_data_i;
    assign w_enq_addr  = w_lsu_fire ? bus.lsu_addr_i : bus.alu_addr_i;

    // Handshakes to x0 complete but leave the FIFO untouched.
    assign w_push = (w_lsu_fire || w_alu_fire) && (w_enq_addr != '0);
    assign w_pop  = bus.wb_en_i && (r_count != '0) && !bus.flush_i;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= w_enq_data;
            r_mem_addr[r_wr_ptr] <= w_enq_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_valid_out <= 1'b0;
            r_data_out  <= '0;
            r_addr_out  <= '0;
        end else if (bus.flush_i) begin
            // Output data/address hold; only the strobe is dropped.
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_valid_out <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_data_out  <= r_mem_data[r_rd_ptr];
                r_addr_out  <= r_mem_addr[r_rd_ptr];
                r_valid_out <= 1'b1;
                r_rd_ptr    <= r_rd_ptr + PTR_W'(1);
            end else begin
                r_valid_out <= 1'b0;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Bypass: walk oldest to youngest so later matches overwrite earlier
    // ones. The output register is the oldest pending write, then FIFO
    // entries from head towards tail-1.
    always_comb begin : p_bypass
        logic [PTR_W-1:0] v_idx;
        w_q1_hit  = 1'b0;
        w_q2_hit  = 1'b0;
        w_q1_data = '0;
        w_q2_data = '0;
        v_idx     = '0;
        if (r_valid_out) begin
            if ((bus.q1_addr_i != '0) && (bus.q1_addr_i == r_addr_out)) begin
                w_q1_hit  = 1'b1;
                w_q1_data = r_data_out;
            end
            if ((bus.q2_addr_i != '0) && (bus.q2_addr_i == r_addr_out)) begin
                w_q2_hit  = 1'b1;
                w_q2_data = r_data_out;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            v_idx = r_rd_ptr + PTR_W'(i);
            if (CNT_W'(i) < r_count) begin
                if ((bus.q1_addr_i != '0) && (bus.q1_addr_i == r_mem_addr[v_idx])) begin
                    w_q1_hit  = 1'b1;
                    w_q1_data = r_mem_data[v_idx];
                end
                if ((bus.q2_addr_i != '0) && (bus.q2_addr_i == r_mem_addr[v_idx])) begin
                    w_q2_hit  = 1'b1;
                    w_q2_data = r_mem_data[v_idx];
                end
            end
        end
    end

    assign bus.lsu_ready_o = w_ready;
    assign bus.alu_ready_o = w_alu_ready;
    assign bus.valid_out_o = r_valid_out;
    assign bus.data_out_o  = r_data_out;
    assign bus.addr_out_o  = r_addr_out;
    assign bus.q1_hit_o    = w_q1_hit;
    assign bus.q2_hit_o    = w_q2_hit;
    assign bus.q1_data_o   = w_q1_data;
    assign bus.q2_data_o   = w_q2_data;
endmodule
`default_nettype wire

// File: tb/tb_wb_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_unit
//  Description : Directed self-checking bench for wb_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    wb_unit_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    wb_unit #(.DATA_W(32), .ADDR_W(5), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.flush_i     = 1'b0;
        bus.wb_en_i     = 1'b0;
        bus.lsu_valid_i = 1'b0;
        bus.lsu_data_i  = '0;
        bus.lsu_addr_i  = '0;
        bus.alu_valid_i = 1'b0;
        bus.alu_data_i  = '0;
        bus.alu_addr_i  = '0;
        bus.q1_addr_i   = '0;
        bus.q2_addr_i   = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        bus.lsu_valid_i = 1'b1;
        bus.lsu_addr_i  = 5'd9;
        tick();
        tick();
        n_checks++; if (bus.lsu_ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_lsu_ready: got %b want 0", bus.lsu_ready_o); end
        n_checks++; if (bus.alu_ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_alu_ready: got %b want 0", bus.alu_ready_o); end
        bus.lsu_valid_i = 1'b0;
        rst = 1'b0;
        tick();
        bus.q1_addr_i = 5'd9;
        bus.q2_addr_i = 5'd9;
        #1;
        n_checks++; if (bus.valid_out_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid_out: got %b want 0", bus.valid_out_o); end
        n_checks++; if (bus.data_out_o !== 32'h0) begin n_fail++; $display("FAIL rst_data_out: got %h want 0", bus.data_out_o); end
        n_checks++; if (bus.addr_out_o !== 5'd0) begin n_fail++; $display("FAIL rst_addr_out: got %0d want 0", bus.addr_out_o); end
        n_checks++; if ({bus.q1_hit_o, bus.q2_hit_o} !== 2'b00) begin n_fail++; $display("FAIL rst_hits: got %b want 00", {bus.q1_hit_o, bus.q2_hit_o}); end
        n_checks++; if ({bus.q1_data_o, bus.q2_data_o} !== 64'h0) begin n_fail++; $display("FAIL rst_qdata: got %h want 0", {bus.q1_data_o, bus.q2_data_o}); end
        n_checks++; if (bus.lsu_ready_o !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready: got %b want 1", bus.lsu_ready_o); end
        idle_inputs();
    endtask

    task automatic test_single_write();
        bus.wb_en_i     = 1'b1;
        bus.lsu_valid_i = 1'b1;
        bus.lsu_data_i  = 32'hDEADBEEF;
        bus.lsu_addr_i  = 5'd5;
        bus.q1_addr_i   = 5'd5;
        #1;
        n_checks++; if (bus.lsu_ready_o !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b want 1", bus.lsu_ready_o); end
        n_checks++; if (bus.q1_hit_o !== 1'b0) begin n_fail++; $display("FAIL single_hit_pre: got %b want 0", bus.q1_hit_o); end
        tick();
        bus.lsu_valid_i = 1'b0;
        #1;
        n_checks++; if (bus.valid_out_o !== 1'b0) begin n_fail++; $display("FAIL single_valid_e0: got %b want 0", bus.valid_out_o); end
        n_checks++; if ({bus.q1_hit_o, bus.q1_data_o} !== {1'b1, 32'hDEADBEEF}) begin n_fail++; $display("FAIL single_bypass_fifo: got %b/%h want 1/deadbeef", bus.q1_hit_o, bus.q1_data_o); end
        tick();
        n_checks++; if ({bus.valid_out_o, bus.addr_out_o, bus.data_out_o} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin n_fail++; $display("FAIL single_strobe: got %b/%0d/%h want 1/5/deadbeef", bus.valid_out_o, bus.addr_out_o, bus.data_out_o); end
        n_checks++; if ({bus.q1_hit_o, bus.q1_data_o} !== {1'b1, 32'hDEADBEEF}) begin n_fail++; $display("FAIL single_bypass_out: got %b/%h want 1/deadbeef", bus.q1_hit_o, bus.q1_data_o); end
        tick();
        n_checks++; if ({bus.valid_out_o, bus.q1_hit_o} !== 2'b00) begin n_fail++; $display("FAIL single_after: got %b want 00", {bus.valid_out_o, bus.q1_hit_o}); end
        idle_inputs();
    endtask

    task automatic test_arbitration();
        bus.wb_en_i     = 1'b1;
        bus.lsu_valid_i = 1'b1; bus.lsu_addr_i = 5'd3; bus.lsu_data_i = 32'h1;
        bus.alu_valid_i = 1'b1; bus.alu_addr_i = 5'd4; bus.alu_data_i = 32'h2;
        #1;
        n_checks++; if ({bus.lsu_ready_o, bus.alu_ready_o} !== 2'b10) begin n_fail++; $display("FAIL arb_readies: got %b want 10", {bus.lsu_ready_o, bus.alu_ready_o}); end
        tick();
        bus.lsu_valid_i = 1'b0;
        #1;
        n_checks++; if (bus.alu_ready_o !== 1'b1) begin n_fail++; $display("FAIL arb_alu_ready: got %b want 1", bus.alu_ready_o); end
        tick();
        bus.alu_valid_i = 1'b0;
        n_checks++; if ({bus.valid_out_o, bus.addr_out_o, bus.data_out_o} !== {1'b1, 5'd3, 32'h1}) begin n_fail++; $display("FAIL arb_first: got %b/%0d/%h want 1/3/1", bus.valid_out_o, bus.addr_out_o, bus.data_out_o); end
        tick();
        n_checks++; if ({bus.valid_out_o, bus.addr_out_o, bus.data_out_o} !== {1'b1, 5'd4, 32'h2}) begin n_fail++; $display("FAIL arb_second: got %b/%0d/%h want 1/4/2", bus.valid_out_o, bus.addr_out_o, bus.data_out_o); end
        tick();
        n_checks++; if (bus.valid_out_o !== 1'b0) begin n_fail++; $display("FAIL arb_idle: got %b want 0", bus.valid_out_o); end
        idle_inputs();
    endtask

    task automatic test_full_wrap();
        int sent;
        int got;
        logic fire;
        bus.wb_en_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            bus.lsu_valid_i = 1'b1;
            bus.lsu_addr_i  = 5'(i);
            bus.lsu_data_i  = 32'h100 + 32'(i);
            #1;
            n_checks++; if (bus.lsu_ready_o !== 1'b1) begin n_fail++; $display("FAIL fill_ready_%0d: got %b want 1", i, bus.lsu_ready_o); end
            tick();
        end
        bus.lsu_valid_i = 1'b0;
        bus.alu_valid_i = 1'b1;
        bus.alu_addr_i  = 5'd20;
        #1;
        n_checks++; if ({bus.lsu_ready_o, bus.alu_ready_o} !== 2'b00) begin n_fail++; $display("FAIL full_readies: got %b want 00", {bus.lsu_ready_o, bus.alu_ready_o}); end
        bus.alu_valid_i = 1'b0;
        bus.wb_en_i = 1'b1;
        sent = 4;
        got  = 0;
        for (int cyc = 0; cyc < 40 && got < 10; cyc++) begin
            bus.lsu_valid_i = (sent < 10);
            bus.lsu_addr_i  = 5'(sent + 1);
            bus.lsu_data_i  = 32'h100 + 32'(sent + 1);
            #1;
            if (cyc == 0) begin
                n_checks++; if (bus.lsu_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_reopen_same_cycle: got %b want 0", bus.lsu_ready_o); end
            end
            fire = bus.lsu_valid_i && bus.lsu_ready_o;
            tick();
            if (fire) sent++;
            if (bus.valid_out_o === 1'b1) begin
                n_checks++;
                if ({bus.addr_out_o, bus.data_out_o} !== {5'(got + 1), 32'h100 + 32'(got + 1)}) begin
                    n_fail++;
                    $display("FAIL wrap_write_%0d: got %0d/%h want %0d/%h", got, bus.addr_out_o, bus.data_out_o, got + 1, 32'h100 + 32'(got + 1));
                end
                got++;
            end
        end
        n_checks++; if (got !== 10) begin n_fail++; $display("FAIL wrap_count: got %0d writes want 10", got); end
        bus.lsu_valid_i = 1'b0;
        tick();
        tick();
        n_checks++; if (bus.valid_out_o !== 1'b0) begin n_fail++; $display("FAIL empty_no_strobe: got %b want 0", bus.valid_out_o); end
        idle_inputs();
    endtask

    task automatic test_youngest_bypass();
        bus.wb_en_i = 1'b0;
        bus.lsu_valid_i = 1'b1; bus.lsu_addr_i = 5'd7; bus.lsu_data_i = 32'hA;
        tick();
        bus.lsu_data_i = 32'hB;
        tick();
        bus.lsu_valid_i = 1'b0;
        bus.q2_addr_i = 5'd7;
        bus.q1_addr_i = 5'd0;
        #1;
        n_checks++; if ({bus.q2_hit_o, bus.q2_data_o} !== {1'b1, 32'hB}) begin n_fail++; $display("FAIL young_fifo: got %b/%h want 1/b", bus.q2_hit_o, bus.q2_data_o); end
        n_checks++; if ({bus.q1_hit_o, bus.q1_data_o} !== {1'b0, 32'h0}) begin n_fail++; $display("FAIL young_x0_query: got %b/%h want 0/0", bus.q1_hit_o, bus.q1_data_o); end
        bus.wb_en_i = 1'b1;
        tick();
        n_checks++; if ({bus.q2_hit_o, bus.q2_data_o} !== {1'b1, 32'hB}) begin n_fail++; $display("FAIL young_over_outreg: got %b/%h want 1/b", bus.q2_hit_o, bus.q2_data_o); end
        tick();
        n_checks++; if ({bus.valid_out_o, bus.q2_hit_o, bus.q2_data_o} !== {1'b1, 1'b1, 32'hB}) begin n_fail++; $display("FAIL young_outreg_only: got %b/%b/%h want 1/1/b", bus.valid_out_o, bus.q2_hit_o, bus.q2_data_o); end
        tick();
        n_checks++; if ({bus.q2_hit_o, bus.q2_data_o} !== {1'b0, 32'h0}) begin n_fail++; $display("FAIL young_drained: got %b/%h want 0/0", bus.q2_hit_o, bus.q2_data_o); end
        idle_inputs();
    endtask

    task automatic test_x0_drop();
        bus.wb_en_i = 1'b1;
        bus.alu_valid_i = 1'b1; bus.alu_addr_i = 5'd0; bus.alu_data_i = 32'h55;
        #1;
        n_checks++; if (bus.alu_ready_o !== 1'b1) begin n_fail++; $display("FAIL x0_ready: got %b want 1", bus.alu_ready_o); end
        tick();
        bus.alu_valid_i = 1'b0;
        tick();
        n_checks++; if (bus.valid_out_o !== 1'b0) begin n_fail++; $display("FAIL x0_no_strobe: got %b want 0", bus.valid_out_o); end
        tick();
        n_checks++; if (bus.valid_out_o !== 1'b0) begin n_fail++; $display("FAIL x0_no_strobe_late: got %b want 0", bus.valid_out_o); end
        idle_inputs();
    endtask

    // use_rst selects whether the mid-operation abort is a flush or a reset.
    task automatic test_abort(input logic use_rst);
        int strobes;
        bus.wb_en_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.lsu_valid_i = 1'b1;
            bus.lsu_addr_i  = 5'(11 + i);
            bus.lsu_data_i  = 32'h200 + 32'(i);
            tick();
        end
        bus.lsu_valid_i = 1'b0;
        bus.wb_en_i = 1'b1;
        tick();
        n_checks++; if ({bus.valid_out_o, bus.addr_out_o} !== {1'b1, 5'd11}) begin n_fail++; $display("FAIL abort%0d_pre_strobe: got %b/%0d want 1/11", use_rst, bus.valid_out_o, bus.addr_out_o); end
        if (use_rst) rst = 1'b1; else bus.flush_i = 1'b1;
        bus.lsu_valid_i = 1'b1; bus.lsu_addr_i = 5'd30; bus.lsu_data_i = 32'h77;
        #1;
        n_checks++; if ({bus.lsu_ready_o, bus.alu_ready_o} !== 2'b00) begin n_fail++; $display("FAIL abort%0d_readies_low: got %b want 00", use_rst, {bus.lsu_ready_o, bus.alu_ready_o}); end
        tick();
        rst = 1'b0;
        bus.flush_i = 1'b0;
        bus.lsu_valid_i = 1'b0;
        bus.q1_addr_i = 5'd12;
        bus.q2_addr_i = 5'd11;
        #1;
        n_checks++; if (bus.valid_out_o !== 1'b0) begin n_fail++; $display("FAIL abort%0d_valid: got %b want 0", use_rst, bus.valid_out_o); end
        n_checks++; if ({bus.q1_hit_o, bus.q2_hit_o} !== 2'b00) begin n_fail++; $display("FAIL abort%0d_hits: got %b want 00", use_rst, {bus.q1_hit_o, bus.q2_hit_o}); end
        n_checks++; if ({bus.lsu_ready_o, bus.alu_ready_o} !== 2'b11) begin n_fail++; $display("FAIL abort%0d_readies: got %b want 11", use_rst, {bus.lsu_ready_o, bus.alu_ready_o}); end
        if (use_rst) begin
            n_checks++; if ({bus.addr_out_o, bus.data_out_o} !== {5'd0, 32'h0}) begin n_fail++; $display("FAIL abort_rst_outregs: got %0d/%h want 0/0", bus.addr_out_o, bus.data_out_o); end
        end else begin
            n_checks++; if ({bus.addr_out_o, bus.data_out_o} !== {5'd11, 32'h200}) begin n_fail++; $display("FAIL abort_flush_hold: got %0d/%h want 11/200", bus.addr_out_o, bus.data_out_o); end
        end
        strobes = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (bus.valid_out_o !== 1'b0) strobes++;
        end
        n_checks++; if (strobes !== 0) begin n_fail++; $display("FAIL abort%0d_stray_writes: got %0d want 0", use_rst, strobes); end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_arbitration();
        test_full_wrap();
        test_youngest_bypass();
        test_x0_drop();
        test_abort(1'b0);
        test_abort(1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
